line_cmd_sched: RTL and testbench

- Command scheduler for the Bresenham line engine.
- Accepts line-segment commands (endpoints and colour) into a small FIFO, then feeds them one at a time to the engine's X1/X2/Y1/Y2/colour/FLAG inputs.
- Services the engine's per-pixel handshake (pixelflag/pixeldone) by issuing SRAM write requests.
- Retires each segment on the engine's done flag and re-arms the engine for the next command.

---
 rtl/line_cmd_sched.sv | 241 ++++++++++++++++++++++++
 tb/tb_line_cmd_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_cmd_sched.sv
// Command scheduler for the Bresenham line engine: buffers segment commands and services per-pixel SRAM writes.
// Optional macro LINE_BBOX_REJECT_EN drops off-screen commands at push time and counts them in odrop_cnt.
module line_cmd_sched #(
  parameter int FIFO_DEPTH = 8,
  parameter int H_MAX      = 640,
  parameter int V_MAX      = 480
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        icmd_valid,
  output logic        ocmd_ready,
  input  logic [9:0]  icmd_x1,
  input  logic [9:0]  icmd_x2,
  input  logic [8:0]  icmd_y1,
  input  logic [8:0]  icmd_y2,
  input  logic [15:0] icmd_color,
  output logic [9:0]  oX1,
  output logic [9:0]  oX2,
  output logic [8:0]  oY1,
  output logic [8:0]  oY2,
  output logic [15:0] ocolor,
  output logic        oFLAG,
  input  logic        ieng_pixelflag,
  input  logic [18:0] ieng_addr,
  input  logic [15:0] ieng_data,
  input  logic        ieng_done,
  output logic        opixeldone,
  output logic        osram_we,
  output logic [18:0] osram_addr,
  output logic [15:0] osram_data,
  input  logic        isram_ack,
  output logic        obusy,
  output logic [15:0] oline_cnt,
  output logic [7:0]  odrop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [9:0]  x1;
    logic [9:0]  x2;
    logic [8:0]  y1;
    logic [8:0]  y2;
    logic [15:0] color;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    PIXW,
    PIXACK,
    RETIRE
  } state_t;

  state_t        state_q, state_d;
  cmd_t          mem_q [FIFO_DEPTH];
  cmd_t          mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ready_q, ready_d;
  cmd_t          cur_q, cur_d;
  logic          flag_q, flag_d;
  logic          we_q, we_d;
  logic [18:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          pixdone_q, pixdone_d;
  logic [15:0]   line_cnt_q, line_cnt_d;

  cmd_t cmd_in;
  logic push;
  logic push_wr;
  logic pop;

  assign cmd_in = '{x1: icmd_x1, x2: icmd_x2, y1: icmd_y1, y2: icmd_y2, color: icmd_color};
  assign push   = icmd_valid && ready_q;
  assign pop    = (state_q == IDLE) && (count_q != '0);

`ifdef LINE_BBOX_REJECT_EN
  localparam logic [10:0] H_LIM = 11'(H_MAX);
  localparam logic [9:0]  V_LIM = 10'(V_MAX);

  logic       in_box;
  logic       drop_inc;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // A rejected command still completes its handshake; it just never reaches the FIFO.
  assign in_box   = ({1'b0, icmd_x1} < H_LIM) && ({1'b0, icmd_x2} < H_LIM) &&
                    ({1'b0, icmd_y1} < V_LIM) && ({1'b0, icmd_y2} < V_LIM);
  assign push_wr  = push && in_box;
  assign drop_inc = push && !in_box;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign odrop_cnt = drop_cnt_q;
`else
  assign push_wr   = push;
  assign odrop_cnt = '0;
`endif

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_wr) begin
      mem_d[wr_ptr_q] = cmd_in;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_wr, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CNT_FULL);
  end

  // Segment sequencing and the engine/SRAM pixel handshake.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    flag_d     = flag_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    pixdone_d  = pixdone_q;
    line_cnt_d = line_cnt_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          cur_d   = mem_q[rd_ptr_q];
          state_d = ARM;
        end
      end
      ARM: begin
        flag_d  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (ieng_done) begin
          flag_d  = 1'b0;
          state_d = RETIRE;
        end else if (ieng_pixelflag) begin
          addr_d  = ieng_addr;
          data_d  = ieng_data;
          we_d    = 1'b1;
          state_d = PIXW;
        end
      end
      PIXW: begin
        if (isram_ack) begin
          we_d      = 1'b0;
          pixdone_d = 1'b1;
          state_d   = PIXACK;
        end
      end
      PIXACK: begin
        if (!ieng_pixelflag) begin
          pixdone_d = 1'b0;
          state_d   = RUN;
        end
      end
      RETIRE: begin
        if (!ieng_done) begin
          line_cnt_d = line_cnt_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q    <= IDLE;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      cur_q      <= '0;
      flag_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      pixdone_q  <= 1'b0;
      line_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      cur_q      <= cur_d;
      flag_q     <= flag_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      pixdone_q  <= pixdone_d;
      line_cnt_q <= line_cnt_d;
    end
  end

  assign ocmd_ready = ready_q;
  assign oX1        = cur_q.x1;
  assign oX2        = cur_q.x2;
  assign oY1        = cur_q.y1;
  assign oY2        = cur_q.y2;
  assign ocolor     = cur_q.color;
  assign oFLAG      = flag_q;
  assign opixeldone = pixdone_q;
  assign osram_we   = we_q;
  assign osram_addr = addr_q;
  assign osram_data = data_q;
  assign obusy      = (state_q != IDLE) || (count_q != '0);
  assign oline_cnt  = line_cnt_q;

endmodule

// File: tb/tb_line_cmd_sched.sv
// Directed self-checking bench for line_cmd_sched; the bench plays the line engine and the SRAM.
// Build with +define+LINE_BBOX_REJECT_EN to exercise the off-screen reject path.
module tb_line_cmd_sched;

  logic        iclk = 1'b0;
  logic        irst_n;
  logic        icmd_valid;
  logic        ocmd_ready;
  logic [9:0]  icmd_x1, icmd_x2;
  logic [8:0]  icmd_y1, icmd_y2;
  logic [15:0] icmd_color;
  logic [9:0]  oX1, oX2;
  logic [8:0]  oY1, oY2;
  logic [15:0] ocolor;
  logic        oFLAG;
  logic        ieng_pixelflag;
  logic [18:0] ieng_addr;
  logic [15:0] ieng_data;
  logic        ieng_done;
  logic        opixeldone;
  logic        osram_we;
  logic [18:0] osram_addr;
  logic [15:0] osram_data;
  logic        isram_ack;
  logic        obusy;
  logic [15:0] oline_cnt;
  logic [7:0]  odrop_cnt;

  int checkCount = 0;
  int failCount  = 0;
  int expLines   = 0;

  always #5 iclk = ~iclk;

  line_cmd_sched dut (
    .iclk(iclk), .irst_n(irst_n),
    .icmd_valid(icmd_valid), .ocmd_ready(ocmd_ready),
    .icmd_x1(icmd_x1), .icmd_x2(icmd_x2), .icmd_y1(icmd_y1), .icmd_y2(icmd_y2),
    .icmd_color(icmd_color),
    .oX1(oX1), .oX2(oX2), .oY1(oY1), .oY2(oY2), .ocolor(ocolor), .oFLAG(oFLAG),
    .ieng_pixelflag(ieng_pixelflag), .ieng_addr(ieng_addr), .ieng_data(ieng_data),
    .ieng_done(ieng_done), .opixeldone(opixeldone),
    .osram_we(osram_we), .osram_addr(osram_addr), .osram_data(osram_data),
    .isram_ack(isram_ack),
    .obusy(obusy), .oline_cnt(oline_cnt), .odrop_cnt(odrop_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [9:0] x1, input logic [9:0] x2,
                               input logic [8:0] y1, input logic [8:0] y2, input logic [15:0] col);
    checkOutput("push_ready", 32'(ocmd_ready), 1);
    icmd_x1    = x1;
    icmd_x2    = x2;
    icmd_y1    = y1;
    icmd_y2    = y2;
    icmd_color = col;
    icmd_valid = 1'b1;
    tick(1);
    icmd_valid = 1'b0;
  endtask

  task automatic waitRun(input logic [9:0] x1, input logic [9:0] x2, input logic [8:0] y1,
                         input logic [8:0] y2, input logic [15:0] col, input int minGap);
    int n = 0;
    while (!oFLAG && n < 50) begin
      tick(1);
      n++;
    end
    checkOutput("flag_rise", 32'(oFLAG), 1);
    if (minGap > 0) checkOutput("flag_gap", 32'(n >= minGap), 1);
    checkOutput("oX1", 32'(oX1), 32'(x1));
    checkOutput("oX2", 32'(oX2), 32'(x2));
    checkOutput("oY1", 32'(oY1), 32'(y1));
    checkOutput("oY2", 32'(oY2), 32'(y2));
    checkOutput("ocolor", 32'(ocolor), 32'(col));
  endtask

  // Engine pixel walk along x, SRAM acknowledging ackDelay cycles after each write request.
  task automatic servicePixels(input logic [9:0] x1, input logic [8:0] y1, input logic [15:0] col,
                               input int npix, input int ackDelay);
    for (int i = 0; i < npix; i++) begin
      logic [18:0] expAddr;
      int n = 0;
      expAddr        = {x1 + 10'(i), y1};
      ieng_addr      = expAddr;
      ieng_data      = col;
      ieng_pixelflag = 1'b1;
      while (!osram_we && n < 20) begin
        tick(1);
        n++;
      end
      checkOutput("we_rise", 32'(osram_we), 1);
      checkOutput("sram_addr", 32'(osram_addr), 32'(expAddr));
      checkOutput("sram_data", 32'(osram_data), 32'(col));
      isram_ack = 1'b0;
      tick(ackDelay);
      checkOutput("we_hold", 32'(osram_we), 1);
      isram_ack = 1'b1;
      tick(1);
      isram_ack = 1'b0;
      checkOutput("we_drop", 32'(osram_we), 0);
      checkOutput("pixeldone_rise", 32'(opixeldone), 1);
      tick(2);
      checkOutput("pixeldone_hold", 32'(opixeldone), 1);
      checkOutput("we_single", 32'(osram_we), 0);
      ieng_pixelflag = 1'b0;
      tick(1);
      checkOutput("pixeldone_fall", 32'(opixeldone), 0);
    end
  endtask

  task automatic retireSegment();
    ieng_done = 1'b1;
    tick(1);
    checkOutput("flag_fall", 32'(oFLAG), 0);
    tick(2);
    checkOutput("flag_held_low", 32'(oFLAG), 0);
    checkOutput("line_cnt_wait", 32'(oline_cnt), 32'(expLines));
    ieng_done = 1'b0;
    tick(1);
    expLines++;
    checkOutput("line_cnt", 32'(oline_cnt), 32'(expLines));
  endtask

  task automatic serviceSegment(input logic [9:0] x1, input logic [9:0] x2, input logic [8:0] y1,
                                input logic [8:0] y2, input logic [15:0] col,
                                input int npix, input int ackDelay, input int minGap);
    waitRun(x1, x2, y1, y2, col, minGap);
    servicePixels(x1, y1, col, npix, ackDelay);
    retireSegment();
  endtask

  initial begin
    int n;
    irst_n = 1'b0;
    icmd_valid = 1'b0;
    icmd_x1 = '0; icmd_x2 = '0; icmd_y1 = '0; icmd_y2 = '0; icmd_color = '0;
    ieng_pixelflag = 1'b0; ieng_addr = '0; ieng_data = '0; ieng_done = 1'b0;
    isram_ack = 1'b0;
    #3;
    checkOutput("rst_ready", 32'(ocmd_ready), 0);
    checkOutput("rst_flag", 32'(oFLAG), 0);
    checkOutput("rst_we", 32'(osram_we), 0);
    checkOutput("rst_pixeldone", 32'(opixeldone), 0);
    checkOutput("rst_busy", 32'(obusy), 0);
    checkOutput("rst_line_cnt", 32'(oline_cnt), 0);
    checkOutput("rst_drop_cnt", 32'(odrop_cnt), 0);
    @(posedge iclk);
    #1;
    irst_n = 1'b1;
    tick(1);
    checkOutput("ready_after_rst", 32'(ocmd_ready), 1);

    // Reset while a pixel write is outstanding, with a second command still queued.
    applyStimulus(10'd5, 10'd9, 9'd1, 9'd1, 16'h1234);
    applyStimulus(10'd7, 10'd7, 9'd2, 9'd2, 16'h0001);
    waitRun(10'd5, 10'd9, 9'd1, 9'd1, 16'h1234, 1);
    ieng_addr = {10'd5, 9'd1};
    ieng_data = 16'h1234;
    ieng_pixelflag = 1'b1;
    n = 0;
    while (!osram_we && n < 20) begin
      tick(1);
      n++;
    end
    checkOutput("midrst_we_before", 32'(osram_we), 1);
    irst_n = 1'b0;
    #1;
    checkOutput("midrst_we", 32'(osram_we), 0);
    checkOutput("midrst_flag", 32'(oFLAG), 0);
    checkOutput("midrst_busy", 32'(obusy), 0);
    ieng_pixelflag = 1'b0;
    ieng_addr = '0;
    ieng_data = '0;
    @(posedge iclk);
    #1;
    irst_n = 1'b1;
    tick(1);
    checkOutput("midrst_ready", 32'(ocmd_ready), 1);
    tick(3);
    checkOutput("midrst_fifo_lost", 32'(obusy), 0);
    checkOutput("midrst_flag_stays", 32'(oFLAG), 0);
    checkOutput("midrst_line_cnt", 32'(oline_cnt), 0);

    // Single segment (0,0)->(3,0): four pixels, SRAM ack two cycles late.
    applyStimulus(10'd0, 10'd3, 9'd0, 9'd0, 16'hF800);
    serviceSegment(10'd0, 10'd3, 9'd0, 9'd0, 16'hF800, 4, 2, 1);
    checkOutput("single_busy", 32'(obusy), 0);
    checkOutput("single_line_cnt", 32'(oline_cnt), 1);

    // Back-to-back pushes; the second lands in the same cycle as the first pop.
    applyStimulus(10'd10, 10'd20, 9'd5, 9'd5, 16'h07E0);
    applyStimulus(10'd30, 10'd31, 9'd6, 9'd6, 16'h001F);
    applyStimulus(10'd40, 10'd40, 9'd7, 9'd8, 16'hFFFF);
    serviceSegment(10'd10, 10'd20, 9'd5, 9'd5, 16'h07E0, 1, 0, 0);
    serviceSegment(10'd30, 10'd31, 9'd6, 9'd6, 16'h001F, 1, 1, 1);
    serviceSegment(10'd40, 10'd40, 9'd7, 9'd8, 16'hFFFF, 1, 3, 1);
    checkOutput("b2b_busy", 32'(obusy), 0);

    // done and pixelflag together in RUN: retire without any SRAM write.
    applyStimulus(10'd50, 10'd60, 9'd9, 9'd9, 16'h5555);
    waitRun(10'd50, 10'd60, 9'd9, 9'd9, 16'h5555, 1);
    ieng_addr = {10'd50, 9'd9};
    ieng_data = 16'h5555;
    ieng_pixelflag = 1'b1;
    ieng_done = 1'b1;
    tick(1);
    checkOutput("both_no_we", 32'(osram_we), 0);
    checkOutput("both_flag_low", 32'(oFLAG), 0);
    tick(2);
    checkOutput("both_still_no_we", 32'(osram_we), 0);
    checkOutput("both_no_pixeldone", 32'(opixeldone), 0);
    ieng_pixelflag = 1'b0;
    ieng_done = 1'b0;
    tick(1);
    expLines++;
    checkOutput("both_line_cnt", 32'(oline_cnt), 32'(expLines));

    // Full FIFO behind a stalled segment: eight fit, the ninth is refused.
    applyStimulus(10'd100, 10'd101, 9'd0, 9'd0, 16'hAAAA);
    waitRun(10'd100, 10'd101, 9'd0, 9'd0, 16'hAAAA, 1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(10'(i), 10'(i + 1), 9'(i), 9'd0, 16'(i * 16'h0111));
    end
    checkOutput("full_ready", 32'(ocmd_ready), 0);
    icmd_x1 = 10'd9; icmd_x2 = 10'd10; icmd_y1 = 9'd9; icmd_y2 = 9'd0; icmd_color = 16'h0999;
    icmd_valid = 1'b1;
    tick(2);
    checkOutput("full_ready_held", 32'(ocmd_ready), 0);
    icmd_valid = 1'b0;
    retireSegment();
    for (int i = 1; i <= 8; i++) begin
      serviceSegment(10'(i), 10'(i + 1), 9'(i), 9'd0, 16'(i * 16'h0111), 0, 0, 1);
    end
    tick(3);
    checkOutput("full_drained_busy", 32'(obusy), 0);
    checkOutput("full_ninth_absent", 32'(oFLAG), 0);
    checkOutput("full_ready_again", 32'(ocmd_ready), 1);

    // Off-screen endpoint x2=640.
    applyStimulus(10'd639, 10'd640, 9'd479, 9'd0, 16'hABCD);
`ifdef LINE_BBOX_REJECT_EN
    checkOutput("bbox_drop_cnt", 32'(odrop_cnt), 1);
    checkOutput("bbox_fifo_empty", 32'(obusy), 0);
    tick(3);
    checkOutput("bbox_no_flag", 32'(oFLAG), 0);
    checkOutput("bbox_still_empty", 32'(obusy), 0);
    applyStimulus(10'd639, 10'd0, 9'd479, 9'd0, 16'h1357);
    serviceSegment(10'd639, 10'd0, 9'd479, 9'd0, 16'h1357, 0, 0, 1);
    checkOutput("bbox_drop_cnt_kept", 32'(odrop_cnt), 1);
`else
    checkOutput("bbox_accepted", 32'(obusy), 1);
    checkOutput("bbox_drop_cnt", 32'(odrop_cnt), 0);
    serviceSegment(10'd639, 10'd640, 9'd479, 9'd0, 16'hABCD, 0, 0, 1);
    checkOutput("bbox_drop_cnt_after", 32'(odrop_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
